// File: rtl/ultrasonic_ranger_if.sv
// Signal bundle between the ultrasonic ranger and its user: sweep control, sensor pins and the
// published per-channel results.
interface ultrasonic_ranger_if #(
  parameter int NUM_CH = 2,
  parameter int W      = 16
);
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              start;
  logic              cont;
  logic [W-1:0]      near_thresh;
  logic [NUM_CH-1:0] echo;
  logic [NUM_CH-1:0] trigger;
  logic              busy;
  logic              valid;
  logic [CHW-1:0]    ch_id;
  logic [W-1:0]      echo_us;
  logic              timeout;
  logic [NUM_CH-1:0] near;

  modport master (
    output start, cont, near_thresh, echo,
    input  trigger, busy, valid, ch_id, echo_us, timeout, near
  );

  modport slave (
    input  start, cont, near_thresh, echo,
    output trigger, busy, valid, ch_id, echo_us, timeout, near
  );
endinterface

// File: rtl/ultrasonic_ranger.sv
// Multi-channel ultrasonic range controller: triggers each sensor in turn, times its echo in
// microseconds and publishes one result (with timeout and near flag) per channel.
module ultrasonic_ranger #(
  parameter int TICK_DIV   = 50,
  parameter int NUM_CH     = 2,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int HOLDOFF_US = 60000,
  parameter int W          = 16
) (
  input logic                clk,
  input logic                rst,
  ultrasonic_ranger_if.slave bus
);
  localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX0 = (TRIG_US > TIMEOUT_US) ? TRIG_US : TIMEOUT_US;
  localparam int TMAX  = (TMAX0 > HOLDOFF_US) ? TMAX0 : HOLDOFF_US;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0]  TRIG_LAST  = TW'(TRIG_US - 1);
  localparam logic [TW-1:0]  WAIT_LAST  = TW'(TIMEOUT_US - 1);
  localparam logic [TW-1:0]  HOLD_LAST  = TW'(HOLDOFF_US - 1);
  localparam logic [W-1:0]   MEAS_LAST  = W'(TIMEOUT_US - 1);
  localparam logic [W-1:0]   SAT        = {W{1'b1}};
  localparam logic [CHW-1:0] CH_LAST    = CHW'(NUM_CH - 1);

  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_RISE, S_MEAS, S_HOLD} state_e;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v == SAT) ? v : v + 1'b1;
  endfunction

  function automatic logic near_hit(input logic [W-1:0] us, input logic to,
                                    input logic [W-1:0] thr);
    return !to && (us < thr);
  endfunction

  state_e            state_q;
  logic [NUM_CH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]     presc_q;
  logic [TW-1:0]     tcnt_q;
  logic [W-1:0]      meas_q;
  logic [CHW-1:0]    ch_q;
  logic [NUM_CH-1:0] trigger_q;
  logic              valid_q;
  logic [CHW-1:0]    ch_id_q;
  logic [W-1:0]      echo_us_q;
  logic              timeout_q;
  logic [NUM_CH-1:0] near_q;

  logic tick;
  logic echo_act;

  assign tick     = (presc_q == PRESC_LAST);
  assign echo_act = sync2_q[ch_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= bus.echo;
      sync2_q <= sync1_q;
    end
  end

  // Every state transition clears the prescaler and the microsecond counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      tcnt_q    <= '0;
      meas_q    <= '0;
      ch_q      <= '0;
      trigger_q <= '0;
      valid_q   <= 1'b0;
      ch_id_q   <= '0;
      echo_us_q <= '0;
      timeout_q <= 1'b0;
      near_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) tcnt_q <= tcnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q   <= S_TRIG;
            ch_q      <= '0;
            trigger_q <= NUM_CH'(1);
            presc_q   <= '0;
            tcnt_q    <= '0;
          end
        end
        S_TRIG: begin
          if (tick && tcnt_q == TRIG_LAST) begin
            state_q   <= S_WAIT_RISE;
            trigger_q <= '0;
            presc_q   <= '0;
            tcnt_q    <= '0;
          end
        end
        S_WAIT_RISE: begin
          if (echo_act) begin
            state_q <= S_MEAS;
            meas_q  <= '0;
            presc_q <= '0;
            tcnt_q  <= '0;
          end else if (tick && tcnt_q == WAIT_LAST) begin
            valid_q        <= 1'b1;
            ch_id_q        <= ch_q;
            echo_us_q      <= SAT;
            timeout_q      <= 1'b1;
            near_q[ch_q]   <= 1'b0;
            state_q        <= S_HOLD;
            presc_q        <= '0;
            tcnt_q         <= '0;
          end
        end
        S_MEAS: begin
          // A falling edge in the same cycle as the timeout tick still counts as a measurement.
          if (!echo_act) begin
            valid_q      <= 1'b1;
            ch_id_q      <= ch_q;
            echo_us_q    <= meas_q;
            timeout_q    <= 1'b0;
            near_q[ch_q] <= near_hit(meas_q, 1'b0, bus.near_thresh);
            state_q      <= S_HOLD;
            presc_q      <= '0;
            tcnt_q       <= '0;
          end else if (tick && meas_q == MEAS_LAST) begin
            valid_q      <= 1'b1;
            ch_id_q      <= ch_q;
            echo_us_q    <= SAT;
            timeout_q    <= 1'b1;
            near_q[ch_q] <= 1'b0;
            state_q      <= S_HOLD;
            presc_q      <= '0;
            tcnt_q       <= '0;
          end else if (tick) begin
            meas_q <= sat_inc(meas_q);
          end
        end
        S_HOLD: begin
          if (tick && tcnt_q == HOLD_LAST) begin
            presc_q <= '0;
            tcnt_q  <= '0;
            if (ch_q != CH_LAST) begin
              state_q   <= S_TRIG;
              ch_q      <= ch_q + 1'b1;
              trigger_q <= NUM_CH'(1) << (ch_q + 1'b1);
            end else if (bus.cont) begin
              state_q   <= S_TRIG;
              ch_q      <= '0;
              trigger_q <= NUM_CH'(1);
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          trigger_q <= '0;
        end
      endcase
    end
  end

  assign bus.trigger = trigger_q;
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.valid   = valid_q;
  assign bus.ch_id   = ch_id_q;
  assign bus.echo_us = echo_us_q;
  assign bus.timeout = timeout_q;
  assign bus.near    = near_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger: a result queue predicted from echo pulse lengths is
// compared against every published result, alongside literal checks of the key scenarios.
module tb_ultrasonic_ranger;
  localparam int TD = 4, NC = 2, TRIG = 10, TO = 100, HO = 5, W = 8;
  localparam int HOLD_CYC = TD * HO;
  localparam int SATV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ultrasonic_ranger_if #(.NUM_CH(NC), .W(W)) bus ();

  ultrasonic_ranger #(
    .TICK_DIV(TD), .NUM_CH(NC), .TRIG_US(TRIG), .TIMEOUT_US(TO), .HOLDOFF_US(HO), .W(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ch;
    int us;
    bit to;
  } res_t;

  res_t          exp_q[$];
  res_t          held;
  logic [NC-1:0] near_m;
  int            checks = 0;
  int            errors = 0;
  int            vcnt   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Result model: a pulse seen high for H cycles yields floor((H-1)/TD) whole microseconds;
  // reaching TO microseconds, or no pulse at all, is a timeout.
  function automatic res_t predict(input int ch, input int h);
    res_t r;
    int   m;
    r.ch = ch;
    m    = (h - 1) / TD;
    if (h == 0 || m >= TO) begin
      r.us = SATV;
      r.to = 1'b1;
    end else begin
      r.us = m;
      r.to = 1'b0;
    end
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      held.ch = 0;
      held.us = 0;
      held.to = 1'b0;
      near_m  = '0;
    end else begin
      chk("trig_onehot", 32'($countones(bus.trigger) <= 1), 1);
      if (bus.valid === 1'b1) begin
        vcnt++;
        chk("valid_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          held = exp_q.pop_front();
          near_m[held.ch] = !held.to && (held.us < int'(bus.near_thresh));
        end
      end
      chk("ch_id", bus.ch_id, held.ch);
      chk("echo_us", bus.echo_us, held.us);
      chk("timeout", bus.timeout, held.to);
      chk("near", bus.near, near_m);
    end
  end

  task automatic reset_check(input string tag);
    chk({tag, "_trigger"}, bus.trigger, 0);
    chk({tag, "_valid"}, bus.valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_near"}, bus.near, 0);
    chk({tag, "_ch_id"}, bus.ch_id, 0);
    chk({tag, "_echo_us"}, bus.echo_us, 0);
    chk({tag, "_timeout"}, bus.timeout, 0);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One channel: wait for its trigger (optionally checking the gap), check its width, then
  // drive an echo pulse of h cycles (0 = none) and wait for the published result.
  task automatic run_ch(input int ch, input int gap, input int d, input int h, input bit poke);
    int k;
    int w;
    k = 0;
    while (bus.trigger[ch] !== 1'b1 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk("trig_seen", 32'(k < 3000), 1);
    if (gap >= 0) chk("trig_gap", k, gap);
    w = 0;
    while (bus.trigger[ch] === 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("trig_width", w, TD * TRIG);
    repeat (d) @(negedge clk);
    exp_q.push_back(predict(ch, h));
    if (h > 0) begin
      bus.echo[ch] = 1'b1;
      if (poke) begin
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (h - 2) @(negedge clk);
      end else begin
        repeat (h) @(negedge clk);
      end
      bus.echo[ch] = 1'b0;
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (bus.valid !== 1'b1 && k < 1000);
    chk("valid_seen", 32'(k < 1000), 1);
    if (h > 0 && !predict(ch, h).to) chk("fall_to_valid", k, 3);
  endtask

  task automatic idle_after_hold(input string tag);
    repeat (HOLD_CYC - 1) @(negedge clk);
    chk({tag, "_busy_in_hold"}, bus.busy, 1);
    @(negedge clk);
    chk({tag, "_busy_after_hold"}, bus.busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int k;
    int hits;
    bus.start       = 1'b0;
    bus.cont        = 1'b0;
    bus.near_thresh = '0;
    bus.echo        = '0;
    repeat (3) @(negedge clk);
    reset_check("por");
    #2 rst = 1'b0;
    @(negedge clk);

    // Scenario 1 and 2: measured ch0, ch1 never answers
    pulse_start();
    run_ch(0, -1, 2, 37 * TD + 1, 1'b0);
    chk("t1_ch_id", bus.ch_id, 0);
    chk("t1_echo_us", bus.echo_us, 37);
    chk("t1_timeout", bus.timeout, 0);
    run_ch(1, HOLD_CYC, 2, 0, 1'b0);
    chk("t2_ch_id", bus.ch_id, 1);
    chk("t2_echo_us", bus.echo_us, 255);
    chk("t2_timeout", bus.timeout, 1);
    chk("t2_near1", bus.near[1], 0);
    idle_after_hold("t2");

    // Scenario 3: near flags
    bus.near_thresh = 8'd50;
    pulse_start();
    run_ch(0, -1, 2, 20 * TD + 1, 1'b0);
    run_ch(1, HOLD_CYC, 2, 80 * TD + 1, 1'b0);
    chk("t3_near_a", bus.near, 2'b01);
    idle_after_hold("t3a");
    pulse_start();
    run_ch(0, -1, 2, 40 * TD + 1, 1'b0);
    chk("t3_near_b", bus.near, 2'b01);
    run_ch(1, HOLD_CYC, 2, 80 * TD + 1, 1'b0);
    idle_after_hold("t3b");

    // Scenario 4: continuous mode, then dropped mid-sweep
    bus.cont = 1'b1;
    pulse_start();
    run_ch(0, -1, 2, 10 * TD + 1, 1'b0);
    run_ch(1, HOLD_CYC, 2, 10 * TD + 1, 1'b0);
    run_ch(0, 20, 2, 10 * TD + 1, 1'b0);
    bus.cont = 1'b0;
    run_ch(1, HOLD_CYC, 2, 10 * TD + 1, 1'b0);
    chk("t4_near", bus.near, 2'b11);
    idle_after_hold("t4");

    // Scenario 5: reset during MEAS, then during TRIG
    pulse_start();
    k = 0;
    while (bus.trigger[0] !== 1'b0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    bus.echo[0] = 1'b1;
    repeat (50) @(negedge clk);
    chk("t5_busy_before", bus.busy, 1);
    #2 rst = 1'b1;
    #1 reset_check("t5_meas");
    exp_q.delete();
    @(negedge clk);
    bus.echo = '0;
    #2 rst = 1'b0;
    v0 = vcnt;
    repeat (600) @(negedge clk);
    chk("t5_no_result", vcnt - v0, 0);
    chk("t5_idle", bus.busy, 0);
    pulse_start();
    repeat (5) @(negedge clk);
    chk("t5_trig_before", bus.trigger, 2'b01);
    #2 rst = 1'b1;
    #1 reset_check("t5_trig");
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    // Scenario 6: start ignored while busy, falling edge on the timeout tick
    v0 = vcnt;
    pulse_start();
    run_ch(0, -1, 2, TO * TD, 1'b1);
    chk("t6_echo_us", bus.echo_us, 99);
    chk("t6_timeout", bus.timeout, 0);
    run_ch(1, HOLD_CYC, 2, TO * TD + 1, 1'b0);
    chk("t6_to_echo_us", bus.echo_us, 255);
    chk("t6_to_timeout", bus.timeout, 1);
    idle_after_hold("t6");
    chk("t6_valid_count", vcnt - v0, 2);
    hits = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.trigger !== '0) hits++;
    end
    chk("t6_no_retrigger", hits, 0);

    chk("exp_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
